// File: rtl/control_unit_pkg.sv
// Shared CPU definitions: opcode constants, control-unit state encoding,
// instruction classes and the control strobe bundle. Imported by the control
// unit, the datapath and their benches.
package cpu_defs;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_ROR  = 5'b01001;
   localparam logic [4:0] OP_ROL  = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_NEG  = 5'b10000;
   localparam logic [4:0] OP_NOT  = 5'b10001;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_IN   = 5'b10101;
   localparam logic [4:0] OP_OUT  = 5'b10110;
   localparam logic [4:0] OP_MFHI = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_NOP  = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11010;

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } cu_state_t;

   typedef enum logic [3:0] {
      C_RTYPE, C_IMM, C_MULDIV, C_UNARY, C_LDI, C_LD, C_ST, C_BR,
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } instr_class_t;

   // One bit per datapath strobe; each bit means "assert for this cycle".
   typedef struct packed {
      logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC;
      logic MARin, MDRin, MDRout, IRin, Yin, Zin, Zhighout, Zlowout;
      logic HIin, HIout, LOin, LOout, CONin, Inportout, Outportin;
      logic Read, Write;
   } strobes_t;

   function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
      return ir[31:27];
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle.
// Handshake: the control unit holds Read (or Write) high each cycle until the
// cycle in which mem_ready is high; that cycle completes the access.
//   master (control unit): in IR, CON_FF, mem_ready; out strb, opcode, run, state
//   slave  (datapath):     the reverse
interface control_unit_if;
   import cpu_defs::*;

   logic [31:0] IR;
   logic        CON_FF;
   logic        mem_ready;
   strobes_t    strb;
   logic [4:0]  opcode;
   logic        run;
   cu_state_t   state;   // debug view of the FSM state

   modport master (input IR, CON_FF, mem_ready, output strb, opcode, run, state);
   modport slave  (output IR, CON_FF, mem_ready, input strb, opcode, run, state);
endinterface

// File: rtl/control_decode.sv
// Combinational opcode -> instruction class decode.
//   op_i    : IR[31:27]
//   class_o : instruction class; unassigned opcodes decode as nop
module control_decode
   import cpu_defs::*;
(
   input  logic [4:0]   op_i,
   output instr_class_t class_o
);

   always_comb begin
      class_o = C_NOP;
      case (op_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
         OP_SHL, OP_ROR, OP_ROL:             class_o = C_RTYPE;
         OP_ADDI, OP_ANDI, OP_ORI:           class_o = C_IMM;
         OP_MUL, OP_DIV:                     class_o = C_MULDIV;
         OP_NEG, OP_NOT:                     class_o = C_UNARY;
         OP_LDI:                             class_o = C_LDI;
         OP_LD:                              class_o = C_LD;
         OP_ST:                              class_o = C_ST;
         OP_BR:                              class_o = C_BR;
         OP_JR:                              class_o = C_JR;
         OP_IN:                              class_o = C_IN;
         OP_OUT:                             class_o = C_OUT;
         OP_MFHI:                            class_o = C_MFHI;
         OP_MFLO:                            class_o = C_MFLO;
         OP_HALT:                            class_o = C_HALT;
         default:                            class_o = C_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: fetch (T0-T2), execute (T3-T7), HALT.
//   Clock : rising-edge clock
//   clear : asynchronous active-low reset, forces state RST
//   bus   : IR / CON_FF / mem_ready in; strobes, ALU opcode, run, state out
// All outputs are combinational from state, IR, CON_FF and mem_ready.
module control_unit
   import cpu_defs::*;
(
   input  logic           Clock,
   input  logic           clear,
   control_unit_if.master bus
);

   cu_state_t    state_q, state_d;
   instr_class_t iclass;
   strobes_t     strb;
   logic [4:0]   op_sel;
   logic         run_sig;
   logic [4:0]   ir_op;
   logic         unused_ir;

   assign ir_op     = ir_opcode(bus.IR);
   assign unused_ir = ^bus.IR[26:0];

   control_decode u_decode (
      .op_i    (ir_op),
      .class_o (iclass)
   );

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) state_q <= S_RST;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      strb    = '0;
      op_sel  = OP_ADD;
      run_sig = 1'b1;
      case (state_q)
         S_RST: state_d = S_T0;
         S_T0: begin
            strb.PCout = 1'b1; strb.MARin = 1'b1; strb.IncPC = 1'b1; strb.Zin = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            // Read/MDRin stay up while waiting; PC is only loaded on exit.
            strb.Zlowout = 1'b1; strb.Read = 1'b1; strb.MDRin = 1'b1;
            if (bus.mem_ready) begin
               strb.PCin = 1'b1;
               state_d   = S_T2;
            end
         end
         S_T2: begin
            strb.MDRout = 1'b1; strb.IRin = 1'b1;
            case (iclass)
               C_NOP:   state_d = S_T0;
               C_HALT:  state_d = S_HALT;
               default: state_d = S_T3;
            endcase
         end
         S_T3: begin
            state_d = S_T4;
            case (iclass)
               C_RTYPE, C_IMM: begin strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1; end
               C_MULDIV:       begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.Yin = 1'b1; end
               C_UNARY: begin
                  strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; op_sel = ir_op;
               end
               C_LDI, C_LD, C_ST: begin strb.Grb = 1'b1; strb.BAout = 1'b1; strb.Yin = 1'b1; end
               C_BR:           begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.CONin = 1'b1; end
               C_JR:   begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.PCin = 1'b1;      state_d = S_T0; end
               C_IN:   begin strb.Inportout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; state_d = S_T0; end
               C_OUT:  begin strb.Gra = 1'b1; strb.Rout = 1'b1; strb.Outportin = 1'b1; state_d = S_T0; end
               C_MFHI: begin strb.HIout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;     state_d = S_T0; end
               C_MFLO: begin strb.LOout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;     state_d = S_T0; end
               default: state_d = S_T0;
            endcase
         end
         S_T4: begin
            state_d = S_T5;
            case (iclass)
               C_RTYPE:  begin strb.Grc = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; op_sel = ir_op; end
               C_IMM:    begin strb.Cout = 1'b1; strb.Zin = 1'b1; op_sel = ir_op; end
               C_MULDIV: begin strb.Grb = 1'b1; strb.Rout = 1'b1; strb.Zin = 1'b1; op_sel = ir_op; end
               C_UNARY: begin
                  strb.Zlowout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;
                  state_d = S_T0;
               end
               C_LDI, C_LD, C_ST: begin strb.Cout = 1'b1; strb.Zin = 1'b1; end  // effective address add
               C_BR:     begin strb.PCout = 1'b1; strb.Yin = 1'b1; end
               default:  state_d = S_T0;
            endcase
         end
         S_T5: begin
            state_d = S_T6;
            case (iclass)
               C_RTYPE, C_IMM, C_LDI: begin
                  strb.Zlowout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1;
                  state_d = S_T0;
               end
               C_MULDIV:   begin strb.Zlowout = 1'b1; strb.LOin = 1'b1; end
               C_LD, C_ST: begin strb.Zlowout = 1'b1; strb.MARin = 1'b1; end
               C_BR:       begin strb.Cout = 1'b1; strb.Zin = 1'b1; end         // branch target add
               default:    state_d = S_T0;
            endcase
         end
         S_T6: begin
            state_d = S_T0;
            case (iclass)
               C_MULDIV: begin strb.Zhighout = 1'b1; strb.HIin = 1'b1; end
               C_LD: begin
                  strb.Read = 1'b1; strb.MDRin = 1'b1;
                  state_d = bus.mem_ready ? S_T7 : S_T6;
               end
               C_ST: begin
                  strb.Gra = 1'b1; strb.Rout = 1'b1; strb.MDRin = 1'b1;
                  state_d = S_T7;
               end
               C_BR: begin
                  if (bus.CON_FF) begin strb.Zlowout = 1'b1; strb.PCin = 1'b1; end
               end
               default: state_d = S_T0;
            endcase
         end
         S_T7: begin
            state_d = S_T0;
            case (iclass)
               C_LD: begin strb.MDRout = 1'b1; strb.Gra = 1'b1; strb.Rin = 1'b1; end
               C_ST: begin
                  strb.Write = 1'b1;
                  state_d = bus.mem_ready ? S_T0 : S_T7;
               end
               default: state_d = S_T0;
            endcase
         end
         S_HALT: begin
            run_sig = 1'b0;
            state_d = S_HALT;
         end
         default: state_d = S_RST;
      endcase
   end

   assign bus.strb   = strb;
   assign bus.opcode = op_sel;
   assign bus.run    = run_sig;
   assign bus.state  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. Each driven cycle pushes the expected
// {state, strobes, opcode, run} record; a monitor pops and compares on the
// falling edge.
module tb_control_unit;
  import cpu_defs::*;

  localparam int W = 4 + $bits(strobes_t) + 5 + 1;

  logic        Clock;
  logic        clear;
  logic [31:0] ir_r;
  logic        mr_r;
  logic        cf_r;
  logic [31:0] cur_ir;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  control_unit_if bus();

  assign bus.IR        = ir_r;
  assign bus.mem_ready = mr_r;
  assign bus.CON_FF    = cf_r;

  control_unit dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: run exceeded time limit, exp_q size %0d", exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- helpers ----------------
  function automatic strobes_t set_bit(input strobes_t e_in, input string tok);
    strobes_t e;
    e = e_in;
    case (tok)
      "Gra":       e.Gra = 1'b1;
      "Grb":       e.Grb = 1'b1;
      "Grc":       e.Grc = 1'b1;
      "Rin":       e.Rin = 1'b1;
      "Rout":      e.Rout = 1'b1;
      "BAout":     e.BAout = 1'b1;
      "Cout":      e.Cout = 1'b1;
      "PCout":     e.PCout = 1'b1;
      "PCin":      e.PCin = 1'b1;
      "IncPC":     e.IncPC = 1'b1;
      "MARin":     e.MARin = 1'b1;
      "MDRin":     e.MDRin = 1'b1;
      "MDRout":    e.MDRout = 1'b1;
      "IRin":      e.IRin = 1'b1;
      "Yin":       e.Yin = 1'b1;
      "Zin":       e.Zin = 1'b1;
      "Zhighout":  e.Zhighout = 1'b1;
      "Zlowout":   e.Zlowout = 1'b1;
      "HIin":      e.HIin = 1'b1;
      "HIout":     e.HIout = 1'b1;
      "LOin":      e.LOin = 1'b1;
      "LOout":     e.LOout = 1'b1;
      "CONin":     e.CONin = 1'b1;
      "Inportout": e.Inportout = 1'b1;
      "Outportin": e.Outportin = 1'b1;
      "Read":      e.Read = 1'b1;
      "Write":     e.Write = 1'b1;
      default: begin
        errors++;
        $display("FAIL strobe_name: got unknown name '%s', required a strobe name", tok);
      end
    endcase
    return e;
  endfunction

  // Space-separated strobe names -> strobe record.
  function automatic strobes_t mk(input string s);
    strobes_t e;
    string    tok;
    e   = '0;
    tok = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (tok != "") e = set_bit(e, tok);
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] mkir(input logic [4:0] op);
    return {op, 27'h0123456};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input cu_state_t st, input string names,
                      input logic [4:0] op = OP_ADD, input logic mr = 1'b1,
                      input logic cf = 1'b0, input logic run_e = 1'b1);
    @(posedge Clock);
    #1;
    ir_r = cur_ir;
    mr_r = mr;
    cf_r = cf;
    exp_q.push_back({st, mk(names), op, run_e});
  endtask

  task automatic fetch(input logic [31:0] ir, input int waits);
    cur_ir = ir;
    step(S_T0, "PCout MARin IncPC Zin");
    repeat (waits) step(S_T1, "Zlowout Read MDRin", OP_ADD, 1'b0);
    step(S_T1, "Zlowout PCin Read MDRin");
    step(S_T2, "MDRout IRin");
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] exp;
    logic [W-1:0] act;
    forever begin
      @(negedge Clock);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act = {bus.state, bus.strb, bus.opcode, bus.run};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL cycle_t%0t: got state=%0d strb=%h op=%b run=%b, required state=%0d strb=%h op=%b run=%b",
                   $time, act[W-1 -: 4], act[W-5 -: 27], act[5:1], act[0],
                   exp[W-1 -: 4], exp[W-5 -: 27], exp[5:1], exp[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b0;
    ir_r   = '0;
    mr_r   = 1'b0;
    cf_r   = 1'b0;
    cur_ir = '0;

    // reset
    step(S_RST, "");
    step(S_RST, "");
    clear = 1'b1;

    // add: six cycles T0..T5
    fetch(32'h18940000, 0);
    step(S_T3, "Grb Rout Yin");
    step(S_T4, "Grc Rout Zin", OP_ADD);
    step(S_T5, "Zlowout Gra Rin");

    // sub with a two-cycle fetch wait
    fetch(mkir(OP_SUB), 2);
    step(S_T3, "Grb Rout Yin");
    step(S_T4, "Grc Rout Zin", OP_SUB);
    step(S_T5, "Zlowout Gra Rin");

    // addi
    fetch(mkir(OP_ADDI), 0);
    step(S_T3, "Grb Rout Yin");
    step(S_T4, "Cout Zin", OP_ADDI);
    step(S_T5, "Zlowout Gra Rin");

    // mul
    fetch(mkir(OP_MUL), 0);
    step(S_T3, "Gra Rout Yin");
    step(S_T4, "Grb Rout Zin", OP_MUL);
    step(S_T5, "Zlowout LOin");
    step(S_T6, "Zhighout HIin");

    // neg
    fetch(mkir(OP_NEG), 0);
    step(S_T3, "Grb Rout Zin", OP_NEG);
    step(S_T4, "Zlowout Gra Rin");

    // ldi
    fetch(mkir(OP_LDI), 0);
    step(S_T3, "Grb BAout Yin");
    step(S_T4, "Cout Zin");
    step(S_T5, "Zlowout Gra Rin");

    // ld with one wait in T6
    fetch(mkir(OP_LD), 0);
    step(S_T3, "Grb BAout Yin");
    step(S_T4, "Cout Zin");
    step(S_T5, "Zlowout MARin");
    step(S_T6, "Read MDRin", OP_ADD, 1'b0);
    step(S_T6, "Read MDRin");
    step(S_T7, "MDRout Gra Rin");

    // st with Write held three extra cycles
    fetch(mkir(OP_ST), 0);
    step(S_T3, "Grb BAout Yin");
    step(S_T4, "Cout Zin");
    step(S_T5, "Zlowout MARin");
    step(S_T6, "Gra Rout MDRin");
    repeat (3) step(S_T7, "Write", OP_ADD, 1'b0);
    step(S_T7, "Write");

    // br not taken, then taken
    for (int t = 0; t < 2; t++) begin
      fetch(mkir(OP_BR), 0);
      step(S_T3, "Gra Rout CONin");
      step(S_T4, "PCout Yin");
      step(S_T5, "Cout Zin");
      if (t == 0) step(S_T6, "", OP_ADD, 1'b1, 1'b0);
      else        step(S_T6, "Zlowout PCin", OP_ADD, 1'b1, 1'b1);
    end

    // single-step ops
    fetch(mkir(OP_JR), 0);   step(S_T3, "Gra Rout PCin");
    fetch(mkir(OP_IN), 0);   step(S_T3, "Inportout Gra Rin");
    fetch(mkir(OP_OUT), 0);  step(S_T3, "Gra Rout Outportin");
    fetch(mkir(OP_MFHI), 0); step(S_T3, "HIout Gra Rin");
    fetch(mkir(OP_MFLO), 0); step(S_T3, "LOout Gra Rin");

    // nop and an unassigned opcode both return to T0 after T2
    fetch(mkir(OP_NOP), 0);
    fetch(mkir(5'b11111), 0);

    // ld interrupted by clear while Read is waiting in T6
    fetch(mkir(OP_LD), 0);
    step(S_T3, "Grb BAout Yin");
    step(S_T4, "Cout Zin");
    step(S_T5, "Zlowout MARin");
    step(S_T6, "Read MDRin", OP_ADD, 1'b0);
    @(posedge Clock);
    #1;
    mr_r = 1'b0;
    check("ld_wait_read_before_clear", {31'd0, bus.strb.Read}, 32'd1);
    #1;
    clear = 1'b0;
    #1;
    check("clear_read_drop", {31'd0, bus.strb.Read}, 32'd0);
    check("clear_state_rst", {28'd0, bus.state}, {28'd0, S_RST});
    exp_q.push_back({S_RST, strobes_t'('0), OP_ADD, 1'b1});
    step(S_RST, "");
    clear = 1'b1;
    fetch(32'h18940000, 0);
    step(S_T3, "Grb Rout Yin");
    step(S_T4, "Grc Rout Zin", OP_ADD);
    step(S_T5, "Zlowout Gra Rin");

    // halt: run low, no strobes, until clear
    fetch(mkir(OP_HALT), 0);
    repeat (20) step(S_HALT, "", OP_ADD, 1'b1, 1'b0, 1'b0);
    @(posedge Clock);
    #1;
    clear = 1'b0;
    #1;
    check("halt_clear_run", {31'd0, bus.run}, 32'd1);
    exp_q.push_back({S_RST, strobes_t'('0), OP_ADD, 1'b1});
    step(S_RST, "");
    clear = 1'b1;
    fetch(mkir(OP_NOP), 0);
    step(S_T0, "PCout MARin IncPC Zin");

    // drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending records, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have these ports: Clock, input, 1, sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have port clear, input, 1, reset; asynchronous, active-low.
REQ-003 The block SHALL have port IR, input, 32, instruction register from datapath; opcode field = IR[31:27].
REQ-004 The block SHALL have port CON_FF, input, 1, branch-condition flag from datapath.
REQ-005 The block SHALL have port mem_ready, input, 1, memory completion; high = the requested Read/Write finishes this cycle.
REQ-006 The block SHALL have these single-bit strobe outputs, each meaning "assert for this cycle": Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zhighout, Zlowout, HIin, HIout, LOin, LOout, CONin, Inportout, Outportin, Read, Write.
REQ-007 The block SHALL have port opcode, output, 5, ALU operation select.
REQ-008 The block SHALL have port run, output, 1, high except in HALT.

Function
REQ-009 The block SHALL use states RST, T0..T7 and HALT. Outputs are combinational from (state, IR, CON_FF, mem_ready); the state register is the only storage.
REQ-010 Opcodes SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010. Any other opcode SHALL execute as nop.
REQ-011 Every strobe not listed for a state SHALL be 0. In ALU steps, opcode = IR[31:27]; in all other states, opcode = 00011 (add).
REQ-012 RST SHALL drive no strobes and go to T0 on the next edge.
REQ-013 Fetch SHALL run as follows:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
REQ-014 In T1, if mem_ready=0, the FSM SHALL stay in T1 with Read and MDRin held high and PCin low; PCin fires only on the exit cycle.
REQ-015 R-type ALU ops (add..rol) SHALL run:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, ALU opcode.
  - T5: Zlowout, Gra, Rin.
  - Then T0.
REQ-016 Immediate ops (addi, andi, ori) SHALL run as REQ-015, except T4 uses Cout in place of Grc/Rout.
REQ-017 mul and div SHALL run:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin, ALU opcode.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then T0.
REQ-018 neg and not SHALL run:
  - T3: Grb, Rout, Zin, ALU opcode.
  - T4: Zlowout, Gra, Rin.
REQ-019 ld, ldi and st SHALL share T3 (Grb, BAout, Yin) and T4 (Cout, Zin, add).
  - ldi: T5 Zlowout, Gra, Rin.
  - ld: T5 Zlowout, MARin; T6 Read, MDRin (waits on mem_ready as in REQ-014); T7 MDRout, Gra, Rin.
  - st: T5 Zlowout, MARin; T6 Gra, Rout, MDRin; T7 Write, held until mem_ready=1.
REQ-020 br SHALL run:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, add.
  - T6: if CON_FF=1, Zlowout and PCin; otherwise no strobes.
REQ-021 The remaining single-step ops SHALL run, in T3:
  - jr: Gra, Rout, PCin.
  - in: Inportout, Gra, Rin.
  - out: Gra, Rout, Outportin.
  - mfhi: HIout, Gra, Rin.
  - mflo: LOout, Gra, Rin.
REQ-022 nop SHALL go T2 -> T0. halt SHALL go T2 -> HALT; HALT drives no strobes, holds run=0, and exits only via clear.
REQ-023 Read and Write SHALL never be high in the same cycle.

Reset
REQ-024 When clear=0, the FSM SHALL enter RST immediately, including mid-instruction and mid-wait, and all strobes SHALL go to 0 within the same cycle.
REQ-025 During reset, opcode SHALL be 00011 and run SHALL be 1.
REQ-026 After clear deasserts, the first rising edge SHALL move the FSM to T0; any in-flight instruction is abandoned.

Structure
REQ-027 Opcode constants and state encodings SHALL live in a shared package, cpu_defs, also used by the datapath and its benches.
REQ-028 One sub-module SHALL decode the opcode into an instruction class: control_decode, combinational, IR[31:27] -> class enum.

Verification
REQ-029 add, IR=0x18940000, mem_ready=1 -> exactly 6 cycles T0..T5; T4 has opcode=00011, Grc, Rout, Zin; T5 has Gra, Rin.
REQ-030 st, mem_ready low 3 cycles in T7 -> Write high 4 cycles, then T0; Read never high in T7.
REQ-031 br with CON_FF=0 -> T6 has PCin=0; with CON_FF=1 -> T6 has Zlowout=1 and PCin=1.
REQ-032 clear pulsed low during ld T6 with Read high -> Read=0 within the same cycle; next fetch starts at T0 one edge after release.
REQ-033 halt 11010 -> run=0 from the cycle after T2, no further strobes for 20 cycles; clear -> run=1.
REQ-034 Opcode 11111 -> behaves as nop: T0, T1, T2, T0, no register strobes.
